// File: rtl/moore_toggle_pulse_encoder_if.sv
// Single-wire toggle link bundle between the pulse encoder and its user:
// level request in, pulse line and status out.
interface moore_toggle_pulse_encoder_if #(
  parameter int CNT_W = 8
);
  logic             level_in;
  logic             dout;
  logic             mirror;
  logic             busy;
  logic [CNT_W-1:0] pulse_cnt;

  modport master (
    input  level_in,
    output dout,
    output mirror,
    output busy,
    output pulse_cnt
  );

  modport slave (
    output level_in,
    input  dout,
    input  mirror,
    input  busy,
    input  pulse_cnt
  );
endinterface

// File: rtl/moore_toggle_pulse_encoder.sv
// Toggle-link transmitter: turns a level into single-cycle pulses so a downstream
// toggle decoder follows it, with a guard gap after every pulse and a pulse counter.
module moore_toggle_pulse_encoder #(
  parameter int GAP_CYC = 2,
  parameter int CNT_W   = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  moore_toggle_pulse_encoder_if.master   link
);

  localparam int GW = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYC);

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_TRACK = 2'd1,
    S_PULSE = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic             dout_reg;
  logic             mirror_reg, mirror_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [GW-1:0]    gap_reg, gap_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= S_INIT;
      dout_reg   <= 1'b0;
      mirror_reg <= 1'b0;
      cnt_reg    <= '0;
      gap_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      // dout is decoded from the next state so the pulse line comes straight off a flop
      dout_reg   <= (state_next == S_PULSE);
      mirror_reg <= mirror_next;
      cnt_reg    <= cnt_next;
      gap_reg    <= gap_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    mirror_next = mirror_reg;
    cnt_next    = cnt_reg;
    gap_next    = gap_reg;
    case (state_reg)
      S_INIT: state_next = S_TRACK;
      S_TRACK: begin
        if (link.level_in != mirror_reg) state_next = S_PULSE;
      end
      S_PULSE: begin
        // the decoder flips on the edge that ends the pulse, so the mirror does too
        mirror_next = ~mirror_reg;
        cnt_next    = cnt_reg + 1'b1;
        if (GAP_CYC > 0) begin
          state_next = S_GAP;
          gap_next   = GAP_LOAD;
        end else begin
          state_next = S_TRACK;
        end
      end
      S_GAP: begin
        if (gap_reg <= GW'(1)) begin
          state_next = S_TRACK;
          gap_next   = '0;
        end else begin
          gap_next = gap_reg - 1'b1;
        end
      end
      default: state_next = S_INIT;
    endcase
  end

  assign link.dout      = dout_reg;
  assign link.mirror    = mirror_reg;
  assign link.busy      = (state_reg != S_TRACK);
  assign link.pulse_cnt = cnt_reg;

endmodule

// File: tb/tb_moore_toggle_pulse_encoder.sv
// Drives three encoders (gap 0, 2, 5) from one level source and checks them against
// a timeline model of compare/pulse instants plus a looped-back toggle decoder.
module tb_moore_toggle_pulse_encoder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic level = 1'b0;

  always #5 clk = ~clk;

  logic [2:0]      dout_v, mirror_v, busy_v;
  logic [2:0][3:0] cnt_v;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int G = (gi == 0) ? 0 : ((gi == 1) ? 2 : 5);
    moore_toggle_pulse_encoder_if #(.CNT_W(4)) link ();
    assign link.level_in = level;
    moore_toggle_pulse_encoder #(.GAP_CYC(G), .CNT_W(4)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .link  (link.master)
    );
    assign dout_v[gi]   = link.dout;
    assign mirror_v[gi] = link.mirror;
    assign busy_v[gi]   = link.busy;
    assign cnt_v[gi]    = link.pulse_cnt;
  end

  int checks = 0;
  int errors = 0;

  // model: edge index since reset release, next compare edge, last pulse window
  int       e_cnt;
  int       ncmp[3], pstart[3], pend[3];
  bit       mir[3], dec[3], prev_dout[3], exp_dout[3], exp_busy[3];
  bit [3:0] mcnt[3];

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic int gap_of(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 2 : 5);
  endfunction

  task automatic model_reset();
    e_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      ncmp[k] = 1; pstart[k] = -10; pend[k] = -10;
      mir[k] = 0; dec[k] = 0; prev_dout[k] = 0;
      exp_dout[k] = 0; exp_busy[k] = 1; mcnt[k] = '0;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin
      if (e_cnt >= 1 && prev_dout[k]) dec[k] = ~dec[k];
      if (e_cnt == pend[k]) begin
        mir[k]  = ~mir[k];
        mcnt[k] = mcnt[k] + 4'd1;
        if (k == 1) $display("pulse done: gap=2 mirror=%0d count=%0d", mir[k], mcnt[k]);
      end
      if (e_cnt == ncmp[k]) begin
        if (level != mir[k]) begin
          pstart[k] = e_cnt;
          pend[k]   = e_cnt + 1;
          ncmp[k]   = e_cnt + gap_of(k) + 2;
        end else begin
          ncmp[k] = e_cnt + 1;
        end
      end
      exp_dout[k] = (pstart[k] == e_cnt);
      exp_busy[k] = (ncmp[k] != e_cnt + 1);
    end
    e_cnt++;
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("dout[g%0d]", gap_of(k)), dout_v[k], exp_dout[k]);
      chk($sformatf("mirror[g%0d]", gap_of(k)), mirror_v[k], mir[k]);
      chk($sformatf("busy[g%0d]", gap_of(k)), busy_v[k], exp_busy[k]);
      chk($sformatf("cnt[g%0d]", gap_of(k)), cnt_v[k], mcnt[k]);
      if (!busy_v[k]) chk($sformatf("loopback[g%0d]", gap_of(k)), dec[k], mirror_v[k]);
      if (gap_of(k) > 0 && prev_dout[k]) chk($sformatf("spacing[g%0d]", gap_of(k)), dout_v[k], 0);
      prev_dout[k] = dout_v[k];
    end
  endtask

  task automatic cycle(input logic lvl);
    level = lvl;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset(input logic lvl);
    rst_n = 1'b0;
    level = lvl;
    @(negedge clk);
    @(negedge clk);
    model_reset();
    check_all();
    rst_n = 1'b1;
  endtask

  initial begin
    // first pulse after release with level held high
    do_reset(1'b1);
    cycle(1'b1); chk("t1 E0 busy", busy_v[1], 0); chk("t1 E0 dout", dout_v[1], 0);
    cycle(1'b1); chk("t1 E1 dout", dout_v[1], 1);
    cycle(1'b1); chk("t1 E2 mirror", mirror_v[1], 1); chk("t1 E2 busy", busy_v[1], 1);
    cycle(1'b1); chk("t1 E3 busy", busy_v[1], 1);
    cycle(1'b1); chk("t1 E4 busy", busy_v[1], 0); chk("t1 E4 cnt", cnt_v[1], 1);

    // fall back to 0, then a 0->1->0 glitch inside the gap
    cycle(1'b0); chk("t2 dout", dout_v[1], 1);
    cycle(1'b0); chk("t2 mirror", mirror_v[1], 0);
    cycle(1'b1);
    cycle(1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0);
    chk("t3 glitch cnt", cnt_v[1], 2);
    chk("t3 glitch mirror", mirror_v[1], 0);

    // two more pulses, then a glitch in the gap that ends at 1
    cycle(1'b1); cycle(1'b1); cycle(1'b1); cycle(1'b1);
    cycle(1'b0); cycle(1'b0);
    chk("t3 setup cnt", cnt_v[1], 4);
    cycle(1'b1); cycle(1'b1);
    cycle(1'b1); chk("t3 late dout", dout_v[1], 1);
    cycle(1'b1); chk("t3 late cnt", cnt_v[1], 5); chk("t3 late mirror", mirror_v[1], 1);

    // 16 pulses: counter 1..15 then wraps to 0
    do_reset(1'b0);
    cycle(1'b0);
    for (int i = 1; i <= 16; i++) begin
      for (int j = 0; j < 8; j++) cycle((i % 2) == 1);
      chk($sformatf("t5 cnt #%0d", i), cnt_v[1], i % 16);
    end
    chk("t5 final mirror", mirror_v[1], 0);

    // random loopback run
    do_reset(1'b0);
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 2) == 0) cycle(~level);
      else cycle(level);
    end

    // asynchronous reset while a pulse is on the line
    do_reset(1'b1);
    cycle(1'b1);
    @(posedge clk);
    model_edge();
    #1;
    chk("t6 pulse before reset", dout_v[1], 1);
    rst_n = 1'b0;
    #1;
    chk("t6 async dout", dout_v[1], 0);
    chk("t6 async mirror", mirror_v[1], 0);
    chk("t6 async cnt", cnt_v[1], 0);
    chk("t6 async busy", busy_v[1], 1);
    do_reset(1'b1);
    cycle(1'b1); chk("t6 INIT no pulse", dout_v[1], 0);
    cycle(1'b1); chk("t6 first pulse", dout_v[1], 1);
    for (int i = 0; i < 6; i++) cycle(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
